bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 87 ++++++++
 tb/tb_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: fetch/mem arbiter onto one MMU port; f_*/m_* upstream req/resp, request_enable/req_*/response_enable/resp_data downstream, busy/grant_mem/proto_err status
module bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_en,
  input  logic        f_req_mode,
  input  logic [31:0] f_req_addr,
  input  logic [31:0] f_req_wdata,
  input  logic [3:0]  f_req_wstrb,
  output logic        f_resp_en,
  output logic [31:0] f_resp_data,
  input  logic        m_req_en,
  input  logic        m_req_mode,
  input  logic [31:0] m_req_addr,
  input  logic [31:0] m_req_wdata,
  input  logic [3:0]  m_req_wstrb,
  output logic        m_resp_en,
  output logic [31:0] m_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy,
  output logic        grant_mem,
  output logic        proto_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic        f_pv, m_pv, f_pm, m_pm;
  logic [31:0] f_pa, m_pa, f_pw, m_pw;
  logic [3:0]  f_ps, m_ps;
  logic        f_cand, m_cand, grant, win_mem, f_own, m_own, f_cap, m_cap, err;
  logic        w_mode;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_wstrb;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    f_cand  = (state == IDLE) && (f_pv || f_req_en);
    m_cand  = (state == IDLE) && (m_pv || m_req_en);
    grant   = f_cand || m_cand;
    win_mem = m_cand && (!f_cand || (ROUND_ROBIN == 1'b0) || !grant_mem);
    f_own   = (state == WAIT) && !grant_mem;
    m_own   = (state == WAIT) && grant_mem;
    f_cap   = f_req_en && !f_pv && !f_own && !(grant && !win_mem);
    m_cap   = m_req_en && !m_pv && !m_own && !(grant && win_mem);
    err     = (f_req_en && (f_pv || f_own)) || (m_req_en && (m_pv || m_own)) ||
              ((state == IDLE) && response_enable);
    w_mode  = win_mem ? (m_pv ? m_pm : m_req_mode)  : (f_pv ? f_pm : f_req_mode);
    w_addr  = win_mem ? (m_pv ? m_pa : m_req_addr)  : (f_pv ? f_pa : f_req_addr);
    w_wdata = win_mem ? (m_pv ? m_pw : m_req_wdata) : (f_pv ? f_pw : f_req_wdata);
    w_wstrb = win_mem ? (m_pv ? m_ps : m_req_wstrb) : (f_pv ? f_ps : f_req_wstrb);
    state_n = (state == IDLE) ? (grant ? WAIT : IDLE) : (response_enable ? IDLE : WAIT);
  end
  always_comb
    busy = (state == WAIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      {f_pv, m_pv, f_pm, m_pm, f_pa, m_pa, f_pw, m_pw, f_ps, m_ps} <= '0;
      {request_enable, req_mode, req_addr, req_wdata, req_wstrb} <= '0;
      {f_resp_en, m_resp_en, f_resp_data, m_resp_data, grant_mem, proto_err} <= '0;
    end else begin
      request_enable <= grant;
      f_resp_en      <= busy && response_enable && !grant_mem;
      m_resp_en      <= busy && response_enable && grant_mem;
      proto_err      <= proto_err || err;
      if (grant) begin
        grant_mem <= win_mem;
        req_mode  <= w_mode;
        req_addr  <= w_addr;
        req_wdata <= w_wdata;
        req_wstrb <= w_wstrb;
      end
      if (busy && response_enable && !grant_mem) f_resp_data <= resp_data;
      if (busy && response_enable && grant_mem) m_resp_data <= resp_data;
      if (grant && !win_mem) f_pv <= 1'b0;
      else if (f_cap) {f_pv, f_pm, f_pa, f_pw, f_ps} <= {1'b1, f_req_mode, f_req_addr, f_req_wdata, f_req_wstrb};
      if (grant && win_mem) m_pv <= 1'b0;
      else if (m_cap) {m_pv, m_pm, m_pa, m_pw, m_ps} <= {1'b1, m_req_mode, m_req_addr, m_req_wdata, m_req_wstrb};
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (round-robin and fixed-priority instances)
module tb_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        f_req_en, f_req_mode, m_req_en, m_req_mode, response_enable;
  logic [31:0] f_req_addr, f_req_wdata, m_req_addr, m_req_wdata, resp_data;
  logic [3:0]  f_req_wstrb, m_req_wstrb;
  logic        f_resp_en, m_resp_en, request_enable, req_mode, busy, grant_mem, proto_err;
  logic [31:0] f_resp_data, m_resp_data, req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        f_resp_en0, m_resp_en0, request_enable0, req_mode0, busy0, grant_mem0, proto_err0;
  logic [31:0] f_resp_data0, m_resp_data0, req_addr0, req_wdata0;
  logic [3:0]  req_wstrb0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bus_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .f_req_en(f_req_en), .f_req_mode(f_req_mode), .f_req_addr(f_req_addr), .f_req_wdata(f_req_wdata), .f_req_wstrb(f_req_wstrb),
    .f_resp_en(f_resp_en), .f_resp_data(f_resp_data),
    .m_req_en(m_req_en), .m_req_mode(m_req_mode), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_en(m_resp_en), .m_resp_data(m_resp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy), .grant_mem(grant_mem), .proto_err(proto_err)
  );
  bus_arbiter #(.ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .f_req_en(f_req_en), .f_req_mode(f_req_mode), .f_req_addr(f_req_addr), .f_req_wdata(f_req_wdata), .f_req_wstrb(f_req_wstrb),
    .f_resp_en(f_resp_en0), .f_resp_data(f_resp_data0),
    .m_req_en(m_req_en), .m_req_mode(m_req_mode), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_en(m_resp_en0), .m_resp_data(m_resp_data0),
    .request_enable(request_enable0), .req_mode(req_mode0), .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy0), .grant_mem(grant_mem0), .proto_err(proto_err0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in;
    {f_req_en, f_req_mode, f_req_addr, f_req_wdata, f_req_wstrb} = '0;
    {m_req_en, m_req_mode, m_req_addr, m_req_wdata, m_req_wstrb} = '0;
    {response_enable, resp_data} = '0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic f_pulse(input logic [31:0] a);
    f_req_en = 1'b1; f_req_addr = a;
  endtask
  task automatic m_pulse(input logic [31:0] a);
    m_req_en = 1'b1; m_req_addr = a;
  endtask
  task automatic respond(input logic [31:0] d);
    response_enable = 1'b1; resp_data = d;
  endtask
  initial begin
    idle_in();
    do_reset();
    chk("rst_req_en", request_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_mem, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_fdata", f_resp_data, 0);
    chk("rst_mresp", m_resp_en, 0);
    chk("rst0_busy", busy0, 0);
    // fetch alone
    f_pulse(32'h1000); f_req_wdata = 32'h55; f_req_wstrb = 4'hf;
    tick(); idle_in();
    chk("f1_req_en", request_enable, 1);
    chk("f1_addr", req_addr, 32'h1000);
    chk("f1_wstrb", req_wstrb, 4'hf);
    chk("f1_busy", busy, 1);
    chk("f1_grant", grant_mem, 0);
    tick();
    chk("f2_req_en", request_enable, 0);
    chk("f2_addr_hold", req_addr, 32'h1000);
    tick(); tick(); tick();
    respond(32'hDEADBEEF);
    tick(); idle_in();
    chk("f6_fresp", f_resp_en, 1);
    chk("f6_fdata", f_resp_data, 32'hDEADBEEF);
    chk("f6_mresp", m_resp_en, 0);
    chk("f6_busy", busy, 0);
    tick();
    chk("f7_fresp", f_resp_en, 0);
    chk("f7_fdata_hold", f_resp_data, 32'hDEADBEEF);
    // ties with round robin
    do_reset();
    f_pulse(32'h10); m_pulse(32'h20);
    tick(); idle_in();
    chk("t1_addr", req_addr, 32'h20);
    chk("t1_grant", grant_mem, 1);
    tick();
    chk("t2_req_en", request_enable, 0);
    respond(32'hAAAA);
    tick(); idle_in();
    chk("t4_mresp", m_resp_en, 1);
    chk("t4_fresp", f_resp_en, 0);
    chk("t4_mdata", m_resp_data, 32'hAAAA);
    chk("t4_req_en", request_enable, 0);
    m_pulse(32'h50);
    tick(); idle_in();
    chk("t5_req_en", request_enable, 1);
    chk("t5_addr", req_addr, 32'h10);
    chk("t5_grant", grant_mem, 0);
    respond(32'hBBBB);
    tick(); idle_in();
    chk("t6_fresp", f_resp_en, 1);
    chk("t6_req_en", request_enable, 0);
    tick();
    chk("t7_req_en", request_enable, 1);
    chk("t7_addr", req_addr, 32'h50);
    chk("t7_grant", grant_mem, 1);
    chk("t7_err", proto_err, 0);
    // fixed priority: mem wins every tie
    do_reset();
    for (int i = 0; i < 3; i++) begin
      f_pulse(32'h100 + i); m_pulse(32'h200 + i);
      tick(); idle_in();
      chk("rr0_grant", grant_mem0, 1);
      chk("rr0_addr", req_addr0, 32'h200 + i);
      respond(32'h0);
      tick(); idle_in();
      chk("rr0_mresp", m_resp_en0, 1);
      tick();
      chk("rr0_fgrant", grant_mem0, 0);
      chk("rr0_faddr", req_addr0, 32'h100 + i);
      respond(32'h0);
      tick(); idle_in();
      chk("rr0_fresp", f_resp_en0, 1);
    end
    // request during wait
    do_reset();
    f_pulse(32'h100);
    tick(); idle_in();
    tick();
    m_pulse(32'h200); m_req_mode = 1'b1; m_req_wdata = 32'h12345678; m_req_wstrb = 4'h3;
    tick(); idle_in();
    respond(32'h77);
    tick(); idle_in();
    chk("w4_fresp", f_resp_en, 1);
    chk("w4_req_en", request_enable, 0);
    tick();
    chk("w5_req_en", request_enable, 1);
    chk("w5_addr", req_addr, 32'h200);
    chk("w5_mode", req_mode, 1);
    chk("w5_wdata", req_wdata, 32'h12345678);
    chk("w5_wstrb", req_wstrb, 4'h3);
    chk("w5_grant", grant_mem, 1);
    // duplicate pending request and spurious response
    do_reset();
    m_pulse(32'h300);
    tick(); idle_in();
    f_pulse(32'h400);
    tick(); idle_in();
    chk("v2_err", proto_err, 0);
    f_pulse(32'h500);
    tick(); idle_in();
    chk("v3_err", proto_err, 1);
    respond(32'h1);
    tick(); idle_in();
    chk("v4_mresp", m_resp_en, 1);
    tick();
    chk("v5_req_en", request_enable, 1);
    chk("v5_addr", req_addr, 32'h400);
    respond(32'h2);
    tick(); idle_in();
    chk("v6_fresp", f_resp_en, 1);
    tick();
    chk("v7_req_en", request_enable, 0);
    respond(32'h3);
    tick(); idle_in();
    chk("v8_fresp", f_resp_en, 0);
    chk("v8_mresp", m_resp_en, 0);
    chk("v8_req_en", request_enable, 0);
    chk("v8_fdata", f_resp_data, 32'h2);
    chk("v8_err", proto_err, 1);
    // reset mid-wait
    do_reset();
    f_pulse(32'h600);
    tick(); idle_in();
    chk("r1_busy", busy, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r4_busy", busy, 0);
    chk("r4_err", proto_err, 0);
    tick();
    respond(32'h9);
    tick(); idle_in();
    chk("r6_fresp", f_resp_en, 0);
    chk("r6_mresp", m_resp_en, 0);
    chk("r6_err", proto_err, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
